// File: rtl/bank_write_router.sv
// Bank write router: registered valid/ready demux of encoded words onto NUM_BANKS memory banks.
// A 2-entry buffer (output + skid) keeps upstream ready fully registered while the output
// entry is stalled. Words whose bank select is out of range are dropped and counted.
module bank_write_router #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_BANKS  = 4,
    parameter int ADDR_WIDTH = 6,
    localparam int PARITY_BITS  = $clog2(DATA_WIDTH) + 1,
    localparam int ENCODED_WORD = DATA_WIDTH + PARITY_BITS,
    localparam int BSEL_W       = $clog2(NUM_BANKS),
    localparam int BADDR_W      = ADDR_WIDTH - BSEL_W
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    input  logic [ENCODED_WORD+1:1] i_data,
    output logic [NUM_BANKS-1:0]    o_bank_valid,
    input  logic [NUM_BANKS-1:0]    i_bank_ready,
    output logic [BADDR_W-1:0]      o_bank_addr,
    output logic [ENCODED_WORD+1:1] o_bank_data,
    output logic                    o_sel_err,
    output logic [7:0]              o_drop_cnt,
    output logic                    o_busy
);

    // Bank count widened by one bit so that the range check also works for powers of two.
    localparam logic [BSEL_W:0] NUM_BANKS_L = (BSEL_W + 1)'(NUM_BANKS);

    // Output entry (drives the banks directly) and skid entry.
    logic [NUM_BANKS-1:0]    r_out_onehot;
    logic [BADDR_W-1:0]      r_out_addr;
    logic [ENCODED_WORD+1:1] r_out_data;
    logic                    r_skid_valid;
    logic [NUM_BANKS-1:0]    r_skid_onehot;
    logic [BADDR_W-1:0]      r_skid_addr;
    logic [ENCODED_WORD+1:1] r_skid_data;
    logic                    r_ready;
    logic                    r_sel_err;
    logic [7:0]              r_drop_cnt;
    logic                    r_busy;

    logic [BSEL_W-1:0]       w_sel;
    logic [BADDR_W-1:0]      w_in_addr;
    logic                    w_sel_ok;
    logic                    w_accept;
    logic                    w_push;
    logic                    w_drop;
    logic [NUM_BANKS-1:0]    w_onehot;
    logic                    w_out_valid;
    logic                    w_drain;
    logic                    w_out_free;

    logic [NUM_BANKS-1:0]    w_out_onehot_d;
    logic [BADDR_W-1:0]      w_out_addr_d;
    logic [ENCODED_WORD+1:1] w_out_data_d;
    logic                    w_skid_valid_d;
    logic [NUM_BANKS-1:0]    w_skid_onehot_d;
    logic [BADDR_W-1:0]      w_skid_addr_d;
    logic [ENCODED_WORD+1:1] w_skid_data_d;

    assign w_sel       = i_addr[ADDR_WIDTH-1 -: BSEL_W];
    assign w_in_addr   = i_addr[BADDR_W-1:0];
    assign w_sel_ok    = ({1'b0, w_sel} < NUM_BANKS_L);
    assign w_accept    = i_valid & r_ready;
    assign w_push      = w_accept & w_sel_ok;
    assign w_drop      = w_accept & ~w_sel_ok;
    assign w_out_valid = |r_out_onehot;
    // Only the strobed bank's ready matters since the output strobe is one-hot.
    assign w_drain     = |(r_out_onehot & i_bank_ready);
    assign w_out_free  = ~w_out_valid | w_drain;

    // Decode the bank select into a one-hot strobe pattern.
    always_comb begin
        w_onehot = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (w_sel == BSEL_W'(k)) begin
                w_onehot[k] = 1'b1;
            end
        end
    end

    // Next state of the output and skid entries; words always leave in acceptance order.
    always_comb begin
        w_out_onehot_d  = r_out_onehot;
        w_out_addr_d    = r_out_addr;
        w_out_data_d    = r_out_data;
        w_skid_valid_d  = r_skid_valid;
        w_skid_onehot_d = r_skid_onehot;
        w_skid_addr_d   = r_skid_addr;
        w_skid_data_d   = r_skid_data;
        if (w_out_free) begin
            if (r_skid_valid) begin
                w_out_onehot_d = r_skid_onehot;
                w_out_addr_d   = r_skid_addr;
                w_out_data_d   = r_skid_data;
                w_skid_valid_d = w_push;
                if (w_push) begin
                    w_skid_onehot_d = w_onehot;
                    w_skid_addr_d   = w_in_addr;
                    w_skid_data_d   = i_data;
                end
            end else begin
                w_out_onehot_d = w_push ? w_onehot : '0;
                if (w_push) begin
                    w_out_addr_d = w_in_addr;
                    w_out_data_d = i_data;
                end
            end
        end else if (w_push) begin
            // Output stalled: the new word waits in the skid entry.
            w_skid_valid_d  = 1'b1;
            w_skid_onehot_d = w_onehot;
            w_skid_addr_d   = w_in_addr;
            w_skid_data_d   = i_data;
        end
    end

    // Entry registers, registered ready/busy and drop bookkeeping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_onehot  <= '0;
            r_out_addr    <= '0;
            r_out_data    <= '0;
            r_skid_valid  <= 1'b0;
            r_skid_onehot <= '0;
            r_skid_addr   <= '0;
            r_skid_data   <= '0;
            r_ready       <= 1'b0;
            r_sel_err     <= 1'b0;
            r_drop_cnt    <= 8'd0;
            r_busy        <= 1'b0;
        end else begin
            r_out_onehot  <= w_out_onehot_d;
            r_out_addr    <= w_out_addr_d;
            r_out_data    <= w_out_data_d;
            r_skid_valid  <= w_skid_valid_d;
            r_skid_onehot <= w_skid_onehot_d;
            r_skid_addr   <= w_skid_addr_d;
            r_skid_data   <= w_skid_data_d;
            r_ready       <= ~w_skid_valid_d;
            r_sel_err     <= w_drop;
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
            r_busy        <= (|w_out_onehot_d) | w_skid_valid_d;
        end
    end

    assign o_ready      = r_ready;
    assign o_bank_valid = r_out_onehot;
    assign o_bank_addr  = r_out_addr;
    assign o_bank_data  = r_out_data;
    assign o_sel_err    = r_sel_err;
    assign o_drop_cnt   = r_drop_cnt;
    assign o_busy       = r_busy;

endmodule

// File: tb/tb_bank_write_router.sv
// Self-checking bench for bank_write_router: a table of back-to-back vectors, a scoreboard of
// accepted words checked at every bank drain, and hand sequences for stall, reset and drops.
module tb_bank_write_router;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    // Four-bank instance
    logic        valid, ready, sel_err, busy;
    logic [5:0]  addr;
    logic [13:1] data, bdata;
    logic [3:0]  bank_valid, bank_ready, baddr;
    logic [7:0]  drop_cnt;

    // Three-bank instance (out-of-range selects)
    logic        v3, ready3, sel_err3, busy3;
    logic [5:0]  a3;
    logic [13:1] d3, bdata3;
    logic [2:0]  bank_valid3, bank_ready3;
    logic [3:0]  baddr3;
    logic [7:0]  drop3;

    bank_write_router #(.DATA_WIDTH(8), .NUM_BANKS(4), .ADDR_WIDTH(6)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready), .i_addr(addr),
        .i_data(data), .o_bank_valid(bank_valid), .i_bank_ready(bank_ready),
        .o_bank_addr(baddr), .o_bank_data(bdata), .o_sel_err(sel_err),
        .o_drop_cnt(drop_cnt), .o_busy(busy)
    );

    bank_write_router #(.DATA_WIDTH(8), .NUM_BANKS(3), .ADDR_WIDTH(6)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v3), .o_ready(ready3), .i_addr(a3),
        .i_data(d3), .o_bank_valid(bank_valid3), .i_bank_ready(bank_ready3),
        .o_bank_addr(baddr3), .o_bank_data(bdata3), .o_sel_err(sel_err3),
        .o_drop_cnt(drop3), .o_busy(busy3)
    );

    typedef struct {
        logic [5:0]  addr;
        logic [13:1] data;
        logic [3:0]  exp_bv;
        logic [3:0]  exp_baddr;
    } vec_t;

    typedef struct {
        logic [3:0]  bv;
        logic [3:0]  baddr;
        logic [13:1] data;
    } sb_t;

    sb_t  sbq[$];
    sb_t  e;
    vec_t tbl[8];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_drain = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare each drain with the oldest accepted word, then record new accepts.
    always @(negedge clk) begin
        if (rst_n) begin
            if ((bank_valid & bank_ready) != 4'b0) begin
                n_drain++;
                if (sbq.size() == 0) begin
                    chk("sb_unexpected_strobe", 32'(bank_valid), 32'h0);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_bank", 32'(bank_valid), 32'(e.bv));
                    chk("sb_addr", 32'(baddr), 32'(e.baddr));
                    chk("sb_data", 32'(bdata), 32'(e.data));
                end
            end
            if (valid && ready) begin
                sbq.push_back('{4'b0001 << addr[5:4], addr[3:0], data});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        int d0;
        rst_n = 1'b0; valid = 1'b0; addr = '0; data = '0; bank_ready = 4'hF;
        v3 = 1'b0; a3 = '0; d3 = '0; bank_ready3 = 3'b111;

        tbl[0] = '{6'b00_0001, 13'h1A01, 4'b0001, 4'h1};
        tbl[1] = '{6'b01_0010, 13'h0B12, 4'b0010, 4'h2};
        tbl[2] = '{6'b10_0100, 13'h1C24, 4'b0100, 4'h4};
        tbl[3] = '{6'b11_1000, 13'h0D38, 4'b1000, 4'h8};
        tbl[4] = '{6'b00_1111, 13'h1E4F, 4'b0001, 4'hF};
        tbl[5] = '{6'b01_0000, 13'h0F50, 4'b0010, 4'h0};
        tbl[6] = '{6'b10_1010, 13'h1065, 4'b0100, 4'hA};
        tbl[7] = '{6'b11_0101, 13'h0177, 4'b1000, 4'h5};

        // Reset values
        #2;
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_bank_valid", 32'(bank_valid), 32'h0);
        chk("rst_addr", 32'(baddr), 32'h0);
        chk("rst_data", 32'(bdata), 32'h0);
        chk("rst_sel_err", 32'(sel_err), 32'h0);
        chk("rst_drop", 32'(drop_cnt), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("ready_before_edge", 32'(ready), 32'h0);
        step();
        chk("ready_after_release", 32'(ready), 32'h1);

        // Single word, one-cycle latency, one-cycle strobe
        valid = 1'b1; addr = 6'b10_0101; data = 13'h00AB;
        step();
        valid = 1'b0;
        chk("first_bank_valid", 32'(bank_valid), 32'h4);
        chk("first_addr", 32'(baddr), 32'h5);
        chk("first_data", 32'(bdata), 32'h0AB);
        chk("first_busy", 32'(busy), 32'h1);
        step();
        chk("first_strobe_end", 32'(bank_valid), 32'h0);
        chk("first_addr_hold", 32'(baddr), 32'h5);
        chk("first_busy_end", 32'(busy), 32'h0);

        // Back-to-back table vectors, all banks ready
        d0 = n_drain;
        for (int i = 0; i < 8; i++) begin
            valid = 1'b1; addr = tbl[i].addr; data = tbl[i].data;
            chk("tbl_ready", 32'(ready), 32'h1);
            step();
            chk("tbl_bank_valid", 32'(bank_valid), 32'(tbl[i].exp_bv));
            chk("tbl_addr", 32'(baddr), 32'(tbl[i].exp_baddr));
            chk("tbl_data", 32'(bdata), 32'(tbl[i].data));
        end
        valid = 1'b0;
        step();
        chk("tbl_busy_end", 32'(busy), 32'h0);
        chk("tbl_drain_count", 32'(n_drain - d0), 32'd8);

        // Stall on bank 1: second word lands in skid, outputs hold
        d0 = n_drain;
        bank_ready = 4'b1101;
        valid = 1'b1; addr = 6'b01_0011; data = 13'h0111;
        step();
        chk("stall_a_valid", 32'(bank_valid), 32'h2);
        addr = 6'b10_0001; data = 13'h0222;
        chk("stall_ready_b", 32'(ready), 32'h1);
        step();
        chk("stall_ready_low", 32'(ready), 32'h0);
        chk("stall_busy", 32'(busy), 32'h1);
        addr = 6'b11_0111; data = 13'h0333;
        for (int j = 0; j < 3; j++) begin
            step();
            chk("stall_hold_valid", 32'(bank_valid), 32'h2);
            chk("stall_hold_addr", 32'(baddr), 32'h3);
            chk("stall_hold_data", 32'(bdata), 32'h0111);
            chk("stall_hold_ready", 32'(ready), 32'h0);
        end
        bank_ready = 4'hF;
        t = 0;
        while (!ready && t < 10) begin
            step();
            t++;
        end
        chk("stall_ready_return", 32'(ready), 32'h1);
        step();
        valid = 1'b0;
        t = 0;
        while (busy && t < 10) begin
            step();
            t++;
        end
        chk("stall_busy_end", 32'(busy), 32'h0);
        chk("stall_ready_end", 32'(ready), 32'h1);
        chk("stall_drain_count", 32'(n_drain - d0), 32'd3);

        // Asynchronous reset with both entries full
        bank_ready = 4'h0;
        valid = 1'b1; addr = 6'b00_0011; data = 13'h0444;
        step();
        addr = 6'b01_0110; data = 13'h0555;
        step();
        valid = 1'b0;
        chk("full_busy", 32'(busy), 32'h1);
        chk("full_ready", 32'(ready), 32'h0);
        chk("full_bank_valid", 32'(bank_valid), 32'h1);
        #2 rst_n = 1'b0;
        sbq.delete();
        #1;
        chk("async_bank_valid", 32'(bank_valid), 32'h0);
        chk("async_addr", 32'(baddr), 32'h0);
        chk("async_data", 32'(bdata), 32'h0);
        chk("async_busy", 32'(busy), 32'h0);
        chk("async_ready", 32'(ready), 32'h0);
        bank_ready = 4'hF;
        repeat (2) @(posedge clk);
        #1 chk("in_reset_no_strobe", 32'(bank_valid), 32'h0);
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", 32'(ready), 32'h1);
        chk("post_rst_no_strobe", 32'(bank_valid), 32'h0);
        valid = 1'b1; addr = 6'b11_1100; data = 13'h0666;
        step();
        valid = 1'b0;
        chk("post_rst_bank", 32'(bank_valid), 32'h8);
        chk("post_rst_data", 32'(bdata), 32'h0666);
        step();
        chk("post_rst_busy", 32'(busy), 32'h0);

        // Three banks: select 3 is dropped, flagged and counted
        v3 = 1'b1; a3 = 6'b11_0010; d3 = 13'h0777;
        step();
        a3 = 6'b00_1010; d3 = 13'h0055;
        chk("drop_sel_err", 32'(sel_err3), 32'h1);
        chk("drop_cnt_one", 32'(drop3), 32'h1);
        chk("drop_no_strobe", 32'(bank_valid3), 32'h0);
        chk("drop_not_busy", 32'(busy3), 32'h0);
        step();
        chk("drop_sel_err_clear", 32'(sel_err3), 32'h0);
        chk("drop_good_bank", 32'(bank_valid3), 32'h1);
        chk("drop_good_addr", 32'(baddr3), 32'hA);
        chk("drop_good_data", 32'(bdata3), 32'h055);
        chk("drop_cnt_still_one", 32'(drop3), 32'h1);
        a3 = 6'b11_0000;
        repeat (300) step();
        chk("drop_ready_stays", 32'(ready3), 32'h1);
        chk("drop_no_strobe_burst", 32'(bank_valid3), 32'h0);
        v3 = 1'b0;
        step();
        chk("drop_saturated", 32'(drop3), 32'hFF);
        chk("drop_sel_err_idle", 32'(sel_err3), 32'h0);
        chk("four_bank_no_drops", 32'(drop_cnt), 32'h0);
        chk("sb_empty", 32'(sbq.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
